// File: rtl/if_stage_if.sv
// if_stage_if
// Groups the instruction-fetch stage signals into one bundle.
//   Hazard control : stall_PC, stall_IF_ID, flush_IF_ID
//   Redirect       : npc_op, npc_target
//   ROM bus        : irom_addr (word address out), irom_inst (data in, one cycle later)
//   IF/ID outputs  : pc_ID, pc4_ID, inst_ID, valid_ID
//   Counters       : cnt_fetch, cnt_stall, cnt_flush
// The master modport is the fetch stage; the slave modport is its environment
// (hazard unit, EX redirect, instruction ROM and the decode stage).
interface if_stage_if #(
  parameter int IROM_AW = 14
);
  logic               stall_PC;
  logic               stall_IF_ID;
  logic               flush_IF_ID;
  logic               npc_op;
  logic [31:0]        npc_target;
  logic [IROM_AW-1:0] irom_addr;
  logic [31:0]        irom_inst;
  logic [31:0]        pc_ID;
  logic [31:0]        pc4_ID;
  logic [31:0]        inst_ID;
  logic               valid_ID;
  logic [31:0]        cnt_fetch;
  logic [31:0]        cnt_stall;
  logic [31:0]        cnt_flush;

  modport master (
    input  stall_PC, stall_IF_ID, flush_IF_ID, npc_op, npc_target, irom_inst,
    output irom_addr, pc_ID, pc4_ID, inst_ID, valid_ID,
           cnt_fetch, cnt_stall, cnt_flush
  );

  modport slave (
    output stall_PC, stall_IF_ID, flush_IF_ID, npc_op, npc_target, irom_inst,
    input  irom_addr, pc_ID, pc4_ID, inst_ID, valid_ID,
           cnt_fetch, cnt_stall, cnt_flush
  );
endinterface

// File: rtl/if_stage.sv
// if_stage
// Instruction fetch stage with the IF/ID pipeline register.
// Ports:
//   clk : single clock, all state on the rising edge
//   rst : synchronous active-high reset
//   bus : if_stage_if.master (hazard controls, redirect, ROM bus, IF/ID outputs,
//         performance counters)
// The ROM is synchronous, so it is addressed with the *next* PC; its data in a
// given cycle therefore belongs to the current pc_IF and fetch has no bubbles.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IROM_AW  = 14
) (
  input  logic         clk,
  input  logic         rst,
  if_stage_if.master   bus
);

  localparam logic [31:0] BUBBLE_INST = 32'h0000_0013;

  logic [31:0] pc_IF;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        load_new;

  logic [31:0] pc_id_q;
  logic [31:0] pc4_id_q;
  logic [31:0] inst_id_q;
  logic        valid_id_q;
  logic [31:0] cnt_fetch_q;
  logic [31:0] cnt_stall_q;
  logic [31:0] cnt_flush_q;

  assign pc_plus4 = pc_IF + 32'd4;

  // Next fetch address: reset beats a redirect, a redirect beats a PC stall.
  // Redirect targets are forced to word alignment.
  always_comb begin
    next_pc = pc_plus4;
    if (rst) begin
      next_pc = RESET_PC;
    end else if (bus.npc_op) begin
      next_pc = bus.npc_target & 32'hFFFF_FFFC;
    end else if (bus.stall_PC) begin
      next_pc = pc_IF;
    end
  end

  assign bus.irom_addr = next_pc[IROM_AW+1:2];

  // A new instruction enters IF/ID only when neither flushed nor stalled.
  assign load_new = !bus.flush_IF_ID && !bus.stall_IF_ID;

  // Fetch PC register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_IF <= RESET_PC;
    end else begin
      pc_IF <= next_pc;
    end
  end

  // IF/ID register: flush inserts a bubble and wins over stall; a stall holds
  // every field, and since pc_IF is held too the ROM keeps re-reading the
  // same word, so no separate capture register is needed.
  always_ff @(posedge clk) begin
    if (rst || bus.flush_IF_ID) begin
      pc_id_q    <= 32'd0;
      pc4_id_q   <= 32'd4;
      inst_id_q  <= BUBBLE_INST;
      valid_id_q <= 1'b0;
    end else if (load_new) begin
      pc_id_q    <= pc_IF;
      pc4_id_q   <= pc_plus4;
      inst_id_q  <= bus.irom_inst;
      valid_id_q <= 1'b1;
    end
  end

  // Performance counters, free-running with natural 32-bit wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_fetch_q <= 32'd0;
      cnt_stall_q <= 32'd0;
      cnt_flush_q <= 32'd0;
    end else begin
      if (load_new) begin
        cnt_fetch_q <= cnt_fetch_q + 32'd1;
      end
      if (bus.stall_IF_ID && !bus.flush_IF_ID) begin
        cnt_stall_q <= cnt_stall_q + 32'd1;
      end
      if (bus.flush_IF_ID) begin
        cnt_flush_q <= cnt_flush_q + 32'd1;
      end
    end
  end

  assign bus.pc_ID     = pc_id_q;
  assign bus.pc4_ID    = pc4_id_q;
  assign bus.inst_ID   = inst_id_q;
  assign bus.valid_ID  = valid_id_q;
  assign bus.cnt_fetch = cnt_fetch_q;
  assign bus.cnt_stall = cnt_stall_q;
  assign bus.cnt_flush = cnt_flush_q;

endmodule
